// File: rtl/program_sequencer_if.sv
// Decoder-facing instruction handshake for program_sequencer.
// The sequencer drives instr/instr_valid as master; the decoder returns instr_ready.
interface program_sequencer_if #(
    parameter int INSTR_W = 8
);
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/program_sequencer.sv
// Multi-program instruction store with its own PC; define SEQ_LOOP_EN to make OUT wrap to pc 0 instead of ending in DONE.
// Latency: start at edge N presents the first instruction after edge N+1; best case one instruction per two cycles.
// Backpressure: instr and pc are held while instr_valid=1 and instr_ready=0; only abort or rst withdraw instr_valid.
module program_sequencer #(
    parameter int              INSTR_W    = 8,
    parameter int              OPC_W      = 4,
    parameter int              DEPTH      = 16,
    parameter int              NUM_PROGS  = 4,
    parameter logic [OPC_W-1:0] OUT_OPCODE = 4'hB,
    parameter                  INIT_FILE  = "",
    parameter int              PSEL_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    localparam int             PC_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [PSEL_W-1:0] prog_sel,
    program_sequencer_if.master dec,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam int  WORDS       = NUM_PROGS * DEPTH;
    localparam int  IDX_W       = (WORDS > 1) ? $clog2(WORDS) : 1;
    // A non-empty INIT_FILE disables the built-in image, leaving every word unprogrammed.
    localparam bit  USE_BUILTIN = (INIT_FILE == "");

    logic [2:0]         state;
    logic [PSEL_W-1:0]  prog;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W:0]   store [WORDS];
    logic [IDX_W-1:0]   fidx;
    logic [INSTR_W:0]   fword;

    function automatic logic [INSTR_W:0] image_word(input int p, input int a);
        logic [7:0] w;
        logic       v;
        w = 8'h00;
        v = 1'b0;
        if (p < 2 && a < 7) begin
            case (a)
                0:       w = 8'h90;
                1:       w = 8'hA4;
                2:       w = (p == 0) ? 8'h21 : 8'h01;
                3:       w = 8'h80;
                4:       w = 8'h50;
                5:       w = 8'h80;
                default: w = 8'hB0;
            endcase
            v = 1'b1;
        end
        return {v, INSTR_W'(w)};
    endfunction

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            store[i] = USE_BUILTIN ? image_word(i / DEPTH, i % DEPTH) : '0;
        end
    end

    assign fidx  = IDX_W'(int'(prog) * DEPTH + int'(pc));
    assign fword = store[fidx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            instr_q <= '0;
            pc      <= '0;
            prog    <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (start) begin
                        prog  <= prog_sel;
                        pc    <= '0;
                        state <= (int'(prog_sel) >= NUM_PROGS) ? S_FAULT : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fword[INSTR_W]) begin
                        instr_q <= fword[INSTR_W-1:0];
                        state   <= S_ISSUE;
                    end else begin
                        state <= S_FAULT;
                    end
                end
                S_ISSUE: begin
                    if (dec.instr_ready) begin
                        // OUT is checked before overrun so an OUT in the last word still terminates cleanly.
                        if (instr_q[INSTR_W-1 -: OPC_W] == OUT_OPCODE) begin
`ifdef SEQ_LOOP_EN
                            pc    <= '0;
                            state <= S_FETCH;
`else
                            state <= S_DONE;
`endif
                        end else if (pc == PC_W'(DEPTH - 1)) begin
                            state <= S_FAULT;
                        end else begin
                            pc    <= pc + PC_W'(1);
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dec.instr       = instr_q;
    assign dec.instr_valid = (state == S_ISSUE);
    assign busy            = (state == S_FETCH) || (state == S_ISSUE);
    assign done            = (state == S_DONE);
    assign fault           = (state == S_FAULT);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer (default DUT plus a DEPTH=4 instance for overrun).
module tb_program_sequencer;

`ifdef SEQ_LOOP_EN
    localparam logic EXP_DONE = 1'b0;
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_DONE = 1'b1;
    localparam logic EXP_BUSY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort;
    logic [2:0] prog_sel;
    logic [3:0] pc;
    logic       busy, done, fault;

    logic       start2;
    logic [0:0] prog_sel2;
    logic [1:0] pc2;
    logic       busy2, done2, fault2;

    int checks = 0;
    int errors = 0;

    logic [7:0] p0 [7] = '{8'h90, 8'hA4, 8'h21, 8'h80, 8'h50, 8'h80, 8'hB0};
    logic [7:0] p1 [7] = '{8'h90, 8'hA4, 8'h01, 8'h80, 8'h50, 8'h80, 8'hB0};

    program_sequencer_if #(.INSTR_W(8)) dif ();
    program_sequencer_if #(.INSTR_W(8)) dif2 ();

    program_sequencer #(.DEPTH(16), .NUM_PROGS(4), .PSEL_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_sel(prog_sel),
        .dec(dif), .pc(pc), .busy(busy), .done(done), .fault(fault)
    );

    program_sequencer #(.DEPTH(4), .NUM_PROGS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .prog_sel(prog_sel2),
        .dec(dif2), .pc(pc2), .busy(busy2), .done(done2), .fault(fault2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; prog_sel = 3'd0;
        start2 = 1'b0; prog_sel2 = 1'b0;
        dif.instr_ready = 1'b1; dif2.instr_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst instr_valid", dif.instr_valid, 0);
        chk("rst instr", dif.instr, 0);
        chk("rst pc", pc, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst fault", fault, 0);

        // Test 1: program 0 with the decoder always ready.
        prog_sel = 3'd0; start = 1'b1; step(); start = 1'b0;
        chk("t1 fetch busy", busy, 1);
        chk("t1 fetch valid", dif.instr_valid, 0);
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("t1 instr%0d", k), dif.instr, p0[k]);
            chk($sformatf("t1 pc%0d", k), pc, k);
            chk($sformatf("t1 valid%0d", k), dif.instr_valid, 1);
            step();
        end
        chk("t1 done", done, EXP_DONE);
        chk("t1 busy", busy, EXP_BUSY);
`ifdef SEQ_LOOP_EN
        chk("t6 loop pc", pc, 0);
        step();
        chk("t6 loop reissue", dif.instr, 8'h90);
        chk("t6 loop valid", dif.instr_valid, 1);
        chk("t6 loop done", done, 0);
        abort = 1'b1; step(); abort = 1'b0;
`endif

        // Test 2: program 1 with a 3-cycle stall at pc 2.
        prog_sel = 3'd1; start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            if (k == 2) begin
                dif.instr_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    step();
                    chk("t2 stall instr", dif.instr, 8'h01);
                    chk("t2 stall pc", pc, 2);
                    chk("t2 stall valid", dif.instr_valid, 1);
                end
                dif.instr_ready = 1'b1;
            end
            chk($sformatf("t2 instr%0d", k), dif.instr, p1[k]);
            chk($sformatf("t2 pc%0d", k), pc, k);
            step();
        end
        chk("t2 done", done, EXP_DONE);
`ifdef SEQ_LOOP_EN
        abort = 1'b1; step(); abort = 1'b0;
`endif

        // Test 3: empty program, then out-of-range select.
        prog_sel = 3'd2; start = 1'b1; step(); start = 1'b0;
        chk("t3 fetch busy", busy, 1);
        chk("t3 fetch valid", dif.instr_valid, 0);
        step();
        chk("t3 empty fault", fault, 1);
        chk("t3 empty valid", dif.instr_valid, 0);
        chk("t3 empty busy", busy, 0);
        prog_sel = 3'd4; start = 1'b1; step(); start = 1'b0;
        chk("t3 range fault", fault, 1);
        chk("t3 range busy", busy, 0);
        chk("t3 range valid", dif.instr_valid, 0);

        // Test 4: abort while issuing pc 3, then simultaneous start+abort.
        prog_sel = 3'd0; start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); step();
        end
        step();
        chk("t4 pre pc", pc, 3);
        chk("t4 pre instr", dif.instr, 8'h80);
        abort = 1'b1; step(); abort = 1'b0;
        chk("t4 abort valid", dif.instr_valid, 0);
        chk("t4 abort pc", pc, 0);
        chk("t4 abort busy", busy, 0);
        chk("t4 abort fault", fault, 0);
        chk("t4 abort done", done, 0);
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        chk("t4 both busy", busy, 0);
        chk("t4 both pc", pc, 0);
        step();
        chk("t4 both later busy", busy, 0);

        // Test 5: start while busy is ignored; rst mid-program; clean rerun.
        prog_sel = 3'd0; start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step(); step();
        end
        step();
        dif.instr_ready = 1'b0;
        prog_sel = 3'd1; start = 1'b1; step(); step(); start = 1'b0;
        chk("t5 busy-start pc", pc, 2);
        chk("t5 busy-start instr", dif.instr, 8'h21);
        chk("t5 busy-start valid", dif.instr_valid, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5 rst valid", dif.instr_valid, 0);
        chk("t5 rst pc", pc, 0);
        chk("t5 rst instr", dif.instr, 0);
        chk("t5 rst busy", busy, 0);
        dif.instr_ready = 1'b1;
        prog_sel = 3'd1; start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("t5 instr%0d", k), dif.instr, p1[k]);
            chk($sformatf("t5 pc%0d", k), pc, k);
            step();
        end
        chk("t5 done", done, EXP_DONE);

        // Overrun: DEPTH=4 instance runs off the end of program 0 without an OUT.
        prog_sel2 = 1'b0; start2 = 1'b1; step(); start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("ovr pc%0d", k), pc2, k);
            chk($sformatf("ovr valid%0d", k), dif2.instr_valid, 1);
            step();
        end
        chk("ovr fault", fault2, 1);
        chk("ovr busy", busy2, 0);
        chk("ovr done", done2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
